mem_access_unit: RTL
====================

# mem_access_unit

Load/store front-end placed directly upstream of the data RAM wrapper. It accepts one memory request at a time from the execute stage and converts byte addresses to word addresses. It performs byte and halfword stores as read-modify-write cycles, because the RAM has only a single word-wide write enable. Load results are sign- or zero-extended and returned on a single-cycle response pulse, with alignment and range checking.

## Interface
- RAM_AW, 16, word-address width of the data RAM; byte address space is 2^(RAM_AW+2) bytes.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE and while rst=0.
- req_we  in  1  1=store, 0=load.
- req_op  in  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned. Codes 100/101 are legal for loads only.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half taken from the low bits.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request rejected: misaligned, out of range, or illegal op. Valid with resp_valid.
- ram_addr  out  RAM_AW  word address to data RAM.
- ram_we  out  1  RAM write enable; the RAM writes on the clk edge ending a cycle with ram_we=1.
- ram_wdata  out  32  RAM write word.
- ram_rdata  in  32  RAM read word; asynchronous, valid in the same cycle as ram_addr.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, ERR.
- Handshake: a request is accepted when req_valid & req_ready. On acceptance the unit latches req_we, req_op, req_addr and req_wdata. Inputs are ignored outside IDLE.
- Error checks run on the accepted request; the first match wins:
  - illegal op (11x, 011, or 10x with req_we=1);
  - req_addr[31:RAM_AW+2] != 0 (out of range);
  - half with addr[0] != 0, or word with addr[1:0] != 0 (misaligned).
  - Any error -> ERR. No RAM write ever occurs for an errored request.
- Word address: ram_addr = latched addr[RAM_AW+1:2]. Lane = addr[1:0]. Little-endian: byte k occupies bits [8k+7:8k], half h occupies bits [16h+15:16h].
- IDLE -> LOAD (load), STORE (word store), RMW_RD (byte/half store), ERR.
- LOAD: on the exit edge, resp_rdata <= the extracted lane, sign-extended (op 000/001) or zero-extended (100/101/010). -> IDLE.
- STORE: ram_we=1, ram_wdata=latched wdata. -> IDLE.
- RMW_RD: ram_we=0. Capture ram_rdata into a merge register, replacing the addressed byte or half with req_wdata[7:0] or [15:0]. -> RMW_WR.
- RMW_WR: ram_we=1, ram_wdata=merge register. -> IDLE.
- ERR: -> IDLE, with resp_err <= 1 and resp_rdata <= 0.
- Response timing: resp_valid is registered and set on every transition into IDLE from a non-IDLE state; it is 0 otherwise. resp_err is 1 only when coming from ERR.
- ram_we = (state is STORE or RMW_WR) & ~rst.
- ram_addr and ram_wdata hold their last values while in IDLE.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, ram_addr 0, ram_wdata 0, ram_we 0. req_ready is 0 while rst is high and 1 in the first cycle after the reset edge.
- Latency, counted from the acceptance cycle N to the resp_valid cycle:
  - load, word store, or error: resp_valid in N+2 (error: N+2 via ERR);
  - byte/half store: resp_valid in N+3.
- Throughput: req_ready is high in the same cycle as resp_valid, so back-to-back requests are accepted in that cycle. Maximum rate: one load every 2 cycles.
- A load following a store to the same word reads the new data, because the RAM write completes on the edge before the LOAD cycle.
- rst mid-operation: at the next edge the unit returns to IDLE and resp_valid is 0. A reset asserted during a STORE or RMW_WR cycle suppresses that write (ram_we=0). A reset in RMW_RD leaves RAM unchanged.

## Test plan
- RAM word 0x10 = 0x8899AABB. LB at addr 0x41 -> resp_rdata 0xFFFFFFAA, resp_err 0, resp_valid 2 cycles after acceptance. LBU at 0x41 -> 0x000000AA. LH at 0x42 -> 0xFFFF8899.
- SB 0x5C to addr 0x43, word initially 0x11223344 -> ram_we high exactly 1 cycle, ram_wdata 0x5C223344. resp_valid 3 cycles after acceptance. Subsequent LW at 0x40 returns 0x5C223344.
- SW 0xDEADBEEF to 0x100, then LW at 0x100 accepted in the resp_valid cycle -> 0xDEADBEEF. req_ready is never low during the resp_valid cycle.
- LW at 0x102, SH at 0x103, and a store with op 100 -> each gives resp_err 1 and resp_rdata 0. ram_we stays 0 throughout; RAM contents are unchanged.
- LW at 0x00040000 with RAM_AW=16 -> resp_err 1 (out of range), with no RAM access side effects.
- SH accepted, rst asserted during the RMW_WR cycle -> ram_we 0 that cycle, target word unchanged, next cycle state IDLE, resp_valid 0. req_ready is 1 after rst deasserts.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end for a word-wide data RAM.
// Ports: req_* (one request at a time), resp_* (one-cycle result pulse),
//        ram_* (word address, write enable/data, async read data).
module mem_access_unit #(
    parameter int RAM_AW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       sdata_q, sdata_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic        accept;
    logic        op_illegal;
    logic        out_of_range;
    logic        misaligned;
    logic        req_error;
    logic [4:0]  lane_shift;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] lane_ins;
    logic [31:0] merge_data;

    assign req_ready  = (state_q == S_IDLE) & ~rst;
    assign accept     = req_valid & req_ready;

    // Unsigned codes are load-only; 011 and 11x are unused encodings.
    assign op_illegal = (req_op[2:1] == 2'b11)
                      | (req_op == 3'b011)
                      | (req_op[2] & req_we);
    assign out_of_range = |req_addr[31:RAM_AW+2];
    assign misaligned   = ((req_op[1:0] == 2'b01) & req_addr[0])
                        | ((req_op[1:0] == 2'b10) & (|req_addr[1:0]));
    assign req_error    = op_illegal | out_of_range | misaligned;

    // Shifting the word down by the lane puts the addressed byte/half
    // at bit 0; for halves lane[0] is always 0 so the same shift works.
    assign lane_shift = {lane_q, 3'b000};
    assign shifted    = ram_rdata >> lane_shift;

    always_comb begin
        load_data = ram_rdata;
        unique case (op_q[1:0])
            2'b00: load_data = {{24{~op_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01: load_data = {{16{~op_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_data = ram_rdata;
        endcase
    end

    always_comb begin
        lane_mask = 32'h0000_00ff << lane_shift;
        lane_ins  = {24'h0, sdata_q[7:0]} << lane_shift;
        if (op_q[1:0] == 2'b01) begin
            lane_mask = 32'h0000_ffff << lane_shift;
            lane_ins  = {16'h0, sdata_q} << lane_shift;
        end
        merge_data = (ram_rdata & ~lane_mask) | lane_ins;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        sdata_d      = sdata_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    lane_d  = req_addr[1:0];
                    sdata_d = req_wdata[15:0];
                    if (req_error) begin
                        // RAM address left untouched for rejected requests.
                        state_d = S_ERR;
                    end else begin
                        ram_addr_d = req_addr[RAM_AW+1:2];
                        if (!req_we) begin
                            state_d = S_LOAD;
                        end else if (req_op == 3'b010) begin
                            ram_wdata_d = req_wdata;
                            state_d     = S_STORE;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end
                end
            end
            S_LOAD: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
                state_d      = S_IDLE;
            end
            S_STORE: begin
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_RMW_RD: begin
                // The write-data register doubles as the merge register.
                ram_wdata_d = merge_data;
                state_d     = S_RMW_WR;
            end
            S_RMW_WR: begin
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_ERR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 3'b000;
            lane_q       <= 2'b00;
            sdata_q      <= 16'h0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            sdata_q      <= sdata_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Reset gates the strobe directly so a write cycle in flight is dropped.
    assign ram_we     = ((state_q == S_STORE) | (state_q == S_RMW_WR)) & ~rst;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
